spi_slave_tx: RTL and testbench

Parametrised SPI slave transmit engine, the next generation of the team's fixed 8-bit MISO shifter. Streams words from an internal TX FIFO onto MISO under an external SPI master, with configurable word width, FIFO depth and SPI mode (CPOL/CPHA). It sits between the compressive-sensing sample/result path (valid/ready producer) and the external SPI bus, replacing the ad-hoc `done`/`signalReceived` gating with a proper handshake.

---
 rtl/spi_slave_tx.sv | 116 +++++++++++
 tb/tb_spi_slave_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI slave transmit engine streaming a TX FIFO onto MISO, MSB first
module spi_slave_tx #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter bit               CPOL  = 1'b0,
    parameter bit               CPHA  = 1'b0,
    parameter logic [WIDTH-1:0] FILL  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCK,
    input  logic                       SSEL,
    output logic                       MISO,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       word_sent,
    output logic                       underflow,
    output logic                       aborted
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [2:0]       sck_q, sck_d, ssel_q, ssel_d;
    logic             init_q, init_d, armed_q, armed_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic             word_sent_q, word_sent_d, underflow_q, underflow_d, aborted_q, aborted_d;
    logic             lead, trail, active, start, stop, sample, launch, load, empty, push, pop;

    // Edge/select decode; frames only start once SSEL has been seen high after reset
    always_comb begin
        lead   = (sck_q[2] == CPOL) && (sck_q[1] != CPOL);
        trail  = (sck_q[2] != CPOL) && (sck_q[1] == CPOL);
        active = armed_q & ~ssel_q[1];
        start  = armed_q & ssel_q[2] & ~ssel_q[1];
        stop   = armed_q & ~ssel_q[2] & ssel_q[1];
        sample = active & (CPHA ? trail : lead);
        launch = active & (CPHA ? lead : trail);
        load   = (launch & (cnt_q == '0)) | (~CPHA & start);
        empty  = (level_q == '0);
        push   = tx_valid & ready_q;
        pop    = load & ~empty;
    end

    // Next-state for synchronisers, bit counter, shifter, FIFO and status pulses
    always_comb begin
        sck_d       = {sck_q[1:0], SCK};
        ssel_d      = {ssel_q[1:0], SSEL};
        init_d      = 1'b1;
        armed_d     = armed_q | (init_q & ssel_q[0]);
        cnt_d       = stop ? '0 : sample ? ((cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + 1'b1) : cnt_q;
        sr_d        = load ? (empty ? FILL : mem_q[rd_q]) : launch ? {sr_q[WIDTH-2:0], 1'b1} : sr_q;
        mem_d       = mem_q;
        if (push) mem_d[wr_q] = tx_data;
        rd_d        = rd_q + PW'(pop);
        wr_d        = wr_q + PW'(push);
        level_d     = level_q + LW'(push) - LW'(pop);
        ready_d     = level_d < LW'(DEPTH);
        word_sent_d = sample & (cnt_q == CW'(WIDTH-1));
        underflow_d = load & empty;
        aborted_d   = stop & (cnt_q != '0);
    end

    // Control and datapath state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q       <= {3{CPOL}};
            ssel_q      <= 3'b111;
            init_q      <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '1;
            rd_q        <= '0;
            wr_q        <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
            word_sent_q <= 1'b0;
            underflow_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            sck_q       <= sck_d;
            ssel_q      <= ssel_d;
            init_q      <= init_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            word_sent_q <= word_sent_d;
            underflow_q <= underflow_d;
            aborted_q   <= aborted_d;
        end
    end

    // FIFO storage needs no reset; level and pointers define its contents
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign MISO      = active ? sr_q[WIDTH-1] : 1'b1;
    assign tx_ready  = ready_q;
    assign level     = level_q;
    assign word_sent = word_sent_q;
    assign underflow = underflow_q;
    assign aborted   = aborted_q;
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: scoreboard bench driving two SPI slave configurations as an SPI master
module tb_spi_slave_tx;
    localparam int HP = 8;

    logic        clk, rst_n;
    logic        sck [2];
    logic        ssel [2];
    logic        txv [2];
    logic [15:0] txd;
    logic        miso [2];
    logic        rdy [2];
    logic [2:0]  lvl [2];
    logic        ws [2];
    logic        uf [2];
    logic        ab [2];

    logic [15:0] rx [2];
    logic [15:0] eq0[$], eq1[$], mf0[$], mf1[$];
    int          exp_ws [2], exp_uf [2], exp_ab [2];
    int          ws_cnt [2], uf_cnt [2], ab_cnt [2];
    int          checks, failures;

    spi_slave_tx #(.WIDTH(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .SCK(sck[0]), .SSEL(ssel[0]), .MISO(miso[0]),
        .tx_data(txd[7:0]), .tx_valid(txv[0]), .tx_ready(rdy[0]), .level(lvl[0]),
        .word_sent(ws[0]), .underflow(uf[0]), .aborted(ab[0])
    );

    spi_slave_tx #(.WIDTH(16), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .SCK(sck[1]), .SSEL(ssel[1]), .MISO(miso[1]),
        .tx_data(txd), .tx_valid(txv[1]), .tx_ready(rdy[1]), .level(lvl[1]),
        .word_sent(ws[1]), .underflow(uf[1]), .aborted(ab[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts pulses and compares each completed word against the oldest expected word
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (uf[d]) uf_cnt[d]++;
                if (ab[d]) ab_cnt[d]++;
                if (ws[d]) begin
                    ws_cnt[d]++;
                    if (d == 0 && eq0.size() > 0) begin
                        e = eq0.pop_front();
                        chk("rx_word_d0", {24'h0, rx[0][7:0]}, {16'h0, e});
                    end else if (d == 1 && eq1.size() > 0) begin
                        e = eq1.pop_front();
                        chk("rx_word_d1", {16'h0, rx[1]}, {16'h0, e});
                    end
                end
            end
        end
    endtask

    task automatic push_word(input int d, input logic [15:0] v);
        logic [15:0] m;
        int sz;
        m  = (d == 1) ? v : {8'h00, v[7:0]};
        sz = (d == 1) ? mf1.size() : mf0.size();
        @(negedge clk);
        txd    = m;
        txv[d] = 1'b1;
        chk("tx_ready", 32'(rdy[d]), 32'(sz < 4));
        if (sz < 4) begin
            if (d == 1) mf1.push_back(m);
            else mf0.push_back(m);
        end
        @(posedge clk);
    endtask

    task automatic idle_tx();
        @(negedge clk);
        txv[0] = 1'b0;
        txv[1] = 1'b0;
    endtask

    task automatic next_word(input int d, output logic [15:0] e);
        if (d == 0 && mf0.size() > 0) e = mf0.pop_front();
        else if (d == 1 && mf1.size() > 0) e = mf1.pop_front();
        else begin
            e = 16'h0001;
            exp_uf[d]++;
        end
    endtask

    // One SSEL-low frame of nw whole words followed by k extra bits (k>0 means abort)
    task automatic frame(input int d, input int nw, input int k);
        int          w, nb;
        logic        pol;
        logic [15:0] e;
        w   = (d == 1) ? 16 : 8;
        pol = (d == 1);
        for (int i = 0; i < nw + ((k > 0) ? 1 : 0); i++) begin
            next_word(d, e);
            if (i < nw) begin
                if (d == 1) eq1.push_back(e);
                else eq0.push_back(e);
            end
        end
        exp_ws[d] += nw;
        if (k > 0) exp_ab[d]++;
        nb = nw * w + k;
        ssel[d] = 1'b0;
        wait_n(HP);
        for (int b = 0; b < nb; b++) begin
            sck[d] = ~pol;
            if (!pol) rx[d] = {rx[d][14:0], miso[d]};
            wait_n(HP);
            if (b == nb - 1 && !pol) break;
            sck[d] = pol;
            if (pol) rx[d] = {rx[d][14:0], miso[d]};
            wait_n(HP);
        end
        ssel[d] = 1'b1;
        wait_n(HP);
        sck[d] = pol;
        wait_n(2 * HP);
        chk("words_pending", (d == 1) ? eq1.size() : eq0.size(), 0);
        chk("word_sent_count", ws_cnt[d], exp_ws[d]);
        chk("underflow_count", uf_cnt[d], exp_uf[d]);
        chk("aborted_count", ab_cnt[d], exp_ab[d]);
        chk("level", 32'(lvl[d]), (d == 1) ? mf1.size() : mf0.size());
        chk("miso_idle", 32'(miso[d]), 1);
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_miso", 32'(miso[d]), 1);
            chk("rst_tx_ready", 32'(rdy[d]), 1);
            chk("rst_level", 32'(lvl[d]), 0);
            chk("rst_pulses", {29'h0, ws[d], uf[d], ab[d]}, 0);
        end
    endtask

    initial begin
        int d, n, nw, k;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        txd = '0;
        for (int i = 0; i < 2; i++) begin
            sck[i] = (i == 1);
            ssel[i] = 1'b1;
            txv[i] = 1'b0;
            rx[i] = '0;
            exp_ws[i] = 0; exp_uf[i] = 0; exp_ab[i] = 0;
            ws_cnt[i] = 0; uf_cnt[i] = 0; ab_cnt[i] = 0;
        end
        fork
            monitor();
        join_none
        wait_n(4);
        chk_reset();
        rst_n = 1'b1;
        wait_n(4);
        chk_reset();

        // Mode 0: two words in one frame
        push_word(0, 16'h00A5);
        push_word(0, 16'h003C);
        idle_tx();
        chk("level_two", 32'(lvl[0]), 2);
        frame(0, 2, 0);

        // Underflow with an empty FIFO sends FILL
        frame(0, 1, 0);

        // Mode 3, 16-bit word
        push_word(1, 16'hBEEF);
        idle_tx();
        frame(1, 1, 0);

        // Abort after 5 sample edges discards the partial word
        push_word(0, 16'h0081);
        push_word(0, 16'h007E);
        idle_tx();
        frame(0, 0, 5);
        frame(0, 1, 0);

        // Full FIFO: five words offered with valid held high
        for (int i = 0; i < 5; i++) push_word(0, 16'h0010 + 16'(i));
        idle_tx();
        chk("full_level", 32'(lvl[0]), 4);
        chk("full_ready", 32'(rdy[0]), 0);
        frame(0, 1, 0);
        chk("ready_after_send", 32'(rdy[0]), 1);
        frame(0, 3, 0);

        // Randomised traffic on both configurations
        for (int it = 0; it < 8; it++) begin
            d  = int'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 4));
            nw = int'($urandom_range(1, 3));
            k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (d == 1) ? 15 : 7)) : 0;
            for (int i = 0; i < n; i++) push_word(d, 16'($urandom));
            idle_tx();
            frame(d, nw, k);
        end

        // Reset mid-frame with SSEL held low
        push_word(0, 16'h00C3);
        push_word(0, 16'h0099);
        idle_tx();
        ssel[0] = 1'b0;
        wait_n(HP);
        for (int b = 0; b < 3; b++) begin
            sck[0] = 1'b1;
            wait_n(HP);
            sck[0] = 1'b0;
            wait_n(HP);
        end
        rst_n = 1'b0;
        mf0.delete();
        mf1.delete();
        wait_n(2);
        chk("midrst_miso", 32'(miso[0]), 1);
        chk("midrst_level", 32'(lvl[0]), 0);
        rst_n = 1'b1;
        wait_n(4);
        for (int b = 0; b < 8; b++) begin
            sck[0] = 1'b1;
            wait_n(HP);
            chk("no_frame_miso_hi", 32'(miso[0]), 1);
            sck[0] = 1'b0;
            wait_n(HP);
            chk("no_frame_miso_lo", 32'(miso[0]), 1);
        end
        chk("no_frame_word_sent", ws_cnt[0], exp_ws[0]);
        chk("no_frame_level", 32'(lvl[0]), 0);
        ssel[0] = 1'b1;
        wait_n(2 * HP);
        push_word(0, 16'h005A);
        idle_tx();
        frame(0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
